snd_i2s_receiver: RTL and testbench

- I2S capture path for the sound IP, the receive counterpart of the playback serial converter.
- Samples SND_LRCLK/SND_DIN on SND_BCLK and deserialises 16-bit left/right samples.
- Packs each frame into one 32-bit word and pushes it into the capture FIFO.
- Driven by the same COMMAND encoding as playback (01 start, 10 pause, 11 stop/reset), with a word-count limit.

---
 rtl/snd_i2s_receiver.sv | 207 ++++++++++++++++++++
 tb/tb_snd_i2s_receiver.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/snd_i2s_receiver.sv
// snd_i2s_receiver: I2S capture path for the sound IP.
// Deserialises left/right samples on SND_BCLK, packs one frame into a
// 32-bit {left, right} word and pushes it into the capture FIFO under
// the same COMMAND encoding as the playback path.
module snd_i2s_receiver #(
  parameter int SAMPLE_BITS = 16,
  parameter int WCNT_W      = 29
) (
  input  logic              SND_BCLK,
  input  logic              MRST,
  input  logic              SND_LRCLK,
  input  logic              SND_DIN,
  input  logic [1:0]        COMMAND,
  input  logic [WCNT_W-1:0] DATASIZE,
  input  logic              FIFOFULL,
  output logic              FIFOWR,
  output logic [31:0]       FIFODIN,
  output logic              FIFORST,
  output logic              BUSY,
  output logic [WCNT_W-1:0] WRCNT,
  output logic              OVERFLOW,
  output logic              FRAMEERR
);

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_SYNC    = 3'd1;
  localparam logic [2:0] ST_CAPTURE = 3'd2;
  localparam logic [2:0] ST_PAUSED  = 3'd3;
  localparam logic [2:0] ST_RESET1  = 3'd4;
  localparam logic [2:0] ST_RESET2  = 3'd5;
  localparam logic [2:0] ST_RESET3  = 3'd6;

  localparam logic [1:0] CMD_START = 2'b01;
  localparam logic [1:0] CMD_PAUSE = 2'b10;
  localparam logic [1:0] CMD_STOP  = 2'b11;

  // Slot positions inside the 64-BCLK frame (slot 0 = LRCLK fall)
  localparam logic [5:0] SLOT_LEFT_FIRST  = 6'd1;
  localparam logic [5:0] SLOT_LEFT_LAST   = 6'(SAMPLE_BITS);
  localparam logic [5:0] SLOT_RISE        = 6'd32;
  localparam logic [5:0] SLOT_RIGHT_FIRST = 6'd33;
  localparam logic [5:0] SLOT_RIGHT_LAST  = 6'(32 + SAMPLE_BITS);
  localparam logic [5:0] SLOT_ONE         = 6'd1;

  localparam logic [WCNT_W-1:0] CNT_ONE = WCNT_W'(1);

  logic [2:0]             r_state;
  logic                   r_lrQ;
  logic [5:0]             r_slot;
  logic [SAMPLE_BITS-1:0] r_left;
  logic [SAMPLE_BITS-1:0] r_right;
  logic                   r_wrPend;
  logic [31:0]            r_fifoDin;
  logic                   r_fifoRst;
  logic [WCNT_W-1:0]      r_wrCnt;
  logic                   r_overflow;
  logic                   r_frameErr;

  logic                   w_fall;
  logic                   w_rise;
  logic                   w_badEdge;
  logic                   w_inLeft;
  logic                   w_inRight;
  logic                   w_fifoWr;
  logic                   w_lastWrite;
  logic                   w_enterReset;
  logic                   w_startNew;
  logic [WCNT_W-1:0]      w_cntNext;
  logic [SAMPLE_BITS:0]   w_leftExt;
  logic [SAMPLE_BITS:0]   w_rightExt;
  logic [SAMPLE_BITS-1:0] w_leftNext;
  logic [SAMPLE_BITS-1:0] w_rightNext;
  logic [31:0]            w_packed;

  // Maps a captured channel onto 16 bits: keep the MSBs, zero-pad low.
  function automatic logic [15:0] packHalf(input logic [SAMPLE_BITS-1:0] v);
    logic [SAMPLE_BITS+15:0] t;
    t = {v, 16'h0000};
    return t[SAMPLE_BITS+15 -: 16];
  endfunction

  assign w_fall    = r_lrQ & ~SND_LRCLK;
  assign w_rise    = ~r_lrQ & SND_LRCLK;
  assign w_badEdge = (w_fall && (r_slot != 6'd0)) || (w_rise && (r_slot != SLOT_RISE));

  assign w_inLeft  = (r_slot >= SLOT_LEFT_FIRST) && (r_slot <= SLOT_LEFT_LAST);
  assign w_inRight = (r_slot >= SLOT_RIGHT_FIRST) && (r_slot <= SLOT_RIGHT_LAST);

  assign w_leftExt   = {r_left, SND_DIN};
  assign w_rightExt  = {r_right, SND_DIN};
  assign w_leftNext  = w_leftExt[SAMPLE_BITS-1:0];
  assign w_rightNext = w_rightExt[SAMPLE_BITS-1:0];
  assign w_packed    = {packHalf(r_left), packHalf(w_rightNext)};

  assign w_fifoWr    = r_wrPend & ~FIFOFULL;
  assign w_cntNext   = r_wrCnt + CNT_ONE;
  assign w_lastWrite = w_fifoWr && (DATASIZE != '0) && (w_cntNext == DATASIZE);

  assign w_enterReset = ((r_state == ST_SYNC) || (r_state == ST_CAPTURE) ||
                         (r_state == ST_PAUSED)) && (COMMAND == CMD_STOP);
  assign w_startNew   = (r_state == ST_IDLE) && (COMMAND == CMD_START);

  assign FIFOWR   = w_fifoWr;
  assign FIFODIN  = r_fifoDin;
  assign FIFORST  = r_fifoRst;
  assign BUSY     = (r_state == ST_SYNC) || (r_state == ST_CAPTURE);
  assign WRCNT    = r_wrCnt;
  assign OVERFLOW = r_overflow;
  assign FRAMEERR = r_frameErr;

  // Previous LRCLK level, used only for edge detection
  always_ff @(posedge SND_BCLK) begin
    r_lrQ <= SND_LRCLK;
  end

  // Capture FSM: slot tracking, channel shifting and word assembly
  always_ff @(posedge SND_BCLK) begin
    if (MRST) begin
      r_state   <= ST_IDLE;
      r_slot    <= '0;
      r_left    <= '0;
      r_right   <= '0;
      r_wrPend  <= 1'b0;
      r_fifoDin <= '0;
    end else begin
      r_wrPend <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (COMMAND == CMD_START) r_state <= ST_SYNC;
        end
        ST_SYNC: begin
          if (COMMAND == CMD_STOP) begin
            r_state <= ST_RESET1;
          end else if (COMMAND == CMD_PAUSE) begin
            r_state <= ST_PAUSED;
          end else if (w_fall) begin
            r_state <= ST_CAPTURE;
            r_slot  <= SLOT_ONE;
          end
        end
        ST_CAPTURE: begin
          if (COMMAND == CMD_STOP) begin
            r_state <= ST_RESET1;
          end else if (COMMAND == CMD_PAUSE) begin
            r_state <= ST_PAUSED;
          end else if (w_badEdge) begin
            if (w_fall) begin
              r_slot <= SLOT_ONE;
            end else begin
              r_state <= ST_SYNC;
            end
          end else if (w_lastWrite) begin
            r_state <= ST_IDLE;
          end else begin
            r_slot <= r_slot + SLOT_ONE;
            if (w_inLeft)  r_left  <= w_leftNext;
            if (w_inRight) r_right <= w_rightNext;
            if (r_slot == SLOT_RIGHT_LAST) begin
              r_wrPend  <= 1'b1;
              r_fifoDin <= w_packed;
            end
          end
        end
        ST_PAUSED: begin
          if (COMMAND == CMD_STOP) begin
            r_state <= ST_RESET1;
          end else if (COMMAND == CMD_START) begin
            r_state <= ST_SYNC;
          end
        end
        ST_RESET1: r_state <= ST_RESET2;
        ST_RESET2: r_state <= ST_RESET3;
        ST_RESET3: r_state <= ST_IDLE;
        default:   r_state <= ST_IDLE;
      endcase
    end
  end

  // Word counter and sticky error flags, cleared on start / stop
  always_ff @(posedge SND_BCLK) begin
    if (MRST || w_enterReset) begin
      r_wrCnt    <= '0;
      r_overflow <= 1'b0;
      r_frameErr <= 1'b0;
    end else begin
      if (w_startNew) begin
        r_wrCnt <= '0;
      end else if (w_fifoWr) begin
        r_wrCnt <= w_cntNext;
      end
      if (r_wrPend && FIFOFULL) r_overflow <= 1'b1;
      if ((r_state == ST_CAPTURE) && (COMMAND != CMD_PAUSE) && w_badEdge)
        r_frameErr <= 1'b1;
    end
  end

  // FIFO reset follows master reset and each cycle of the reset sequence
  always_ff @(posedge SND_BCLK) begin
    if (MRST) begin
      r_fifoRst <= 1'b1;
    end else begin
      r_fifoRst <= (r_state == ST_RESET1) || (r_state == ST_RESET2) ||
                   (r_state == ST_RESET3);
    end
  end

endmodule

// File: tb/tb_snd_i2s_receiver.sv
// tb_snd_i2s_receiver: drives whole I2S frames into snd_i2s_receiver and
// compares per-frame outcomes against a frame-level behavioural model.
module tb_snd_i2s_receiver;

  localparam int SB         = 16;
  localparam int WW         = 29;
  localparam int WRITE_SLOT = 33 + SB;

  logic          SND_BCLK;
  logic          MRST;
  logic          SND_LRCLK;
  logic          SND_DIN;
  logic [1:0]    COMMAND;
  logic [WW-1:0] DATASIZE;
  logic          FIFOFULL;
  logic          FIFOWR;
  logic [31:0]   FIFODIN;
  logic          FIFORST;
  logic          BUSY;
  logic [WW-1:0] WRCNT;
  logic          OVERFLOW;
  logic          FRAMEERR;

  int checks   = 0;
  int failures = 0;

  // Frame-level model of the receiver
  bit mCapturing = 0;
  bit mArmed     = 0;
  bit mPaused    = 0;
  bit mOvf       = 0;
  bit mFerr      = 0;
  int mCount     = 0;
  int mLimit     = 0;

  snd_i2s_receiver #(.SAMPLE_BITS(SB), .WCNT_W(WW)) dut (
    .SND_BCLK (SND_BCLK),
    .MRST     (MRST),
    .SND_LRCLK(SND_LRCLK),
    .SND_DIN  (SND_DIN),
    .COMMAND  (COMMAND),
    .DATASIZE (DATASIZE),
    .FIFOFULL (FIFOFULL),
    .FIFOWR   (FIFOWR),
    .FIFODIN  (FIFODIN),
    .FIFORST  (FIFORST),
    .BUSY     (BUSY),
    .WRCNT    (WRCNT),
    .OVERFLOW (OVERFLOW),
    .FRAMEERR (FRAMEERR)
  );

  // Free-running bit clock
  initial SND_BCLK = 1'b0;
  always #5 SND_BCLK = ~SND_BCLK;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic issueStart();
    @(negedge SND_BCLK);
    COMMAND = 2'b01;
    if (mPaused) begin
      mPaused = 0;
      mArmed  = 1;
    end else if (!mCapturing && !mArmed) begin
      mArmed = 1;
      mCount = 0;
    end
    @(negedge SND_BCLK);
    checkOutput("start.busy", 32'(BUSY), 32'(mCapturing || mArmed));
    checkOutput("start.wrcnt", 32'(WRCNT), 32'(mCount));
    COMMAND = 2'b00;
  endtask

  // One 64-BCLK frame; bit k is driven after the k-th negedge so the DUT
  // sees it as slot k. Optional command / reset injection at given slots.
  task automatic applyStimulus(input string name, input logic [15:0] l,
                               input logic [15:0] r, input int riseSlot,
                               input bit full, input int cmdSlot,
                               input logic [1:0] cmdVal, input int mrstSlot);
    bit          killed;
    bit          expWrite;
    int          expRst;
    int          wrPulses;
    int          wrSlot;
    logic [31:0] wrData;
    int          rstCycles;

    if (mArmed) begin
      mCapturing = 1;
      mArmed     = 0;
    end
    killed = (riseSlot != 32) ||
             (cmdSlot >= 0 && cmdSlot <= WRITE_SLOT - 1 && cmdVal[1]) ||
             (mrstSlot >= 0 && mrstSlot <= WRITE_SLOT - 1);
    expWrite = mCapturing && !killed && !full;
    expRst   = 0;
    if (mCapturing && !killed && full) mOvf = 1;
    if (mCapturing && riseSlot != 32 && cmdSlot < 0 && mrstSlot < 0) mFerr = 1;
    if (expWrite) begin
      mCount++;
      if (mLimit != 0 && mCount == mLimit) mCapturing = 0;
    end
    if (cmdSlot >= 0 && cmdVal == 2'b10 && (mCapturing || mArmed)) begin
      mCapturing = 0;
      mArmed     = 0;
      mPaused    = 1;
    end
    if (cmdSlot >= 0 && cmdVal == 2'b01) begin
      if (mPaused) begin
        mPaused = 0;
        mArmed  = 1;
      end else if (!mCapturing && !mArmed) begin
        mArmed = 1;
        mCount = 0;
      end
    end
    if (cmdSlot >= 0 && cmdVal == 2'b11 && (mCapturing || mArmed || mPaused)) begin
      mCapturing = 0; mArmed = 0; mPaused = 0;
      mCount = 0; mOvf = 0; mFerr = 0;
      expRst = 3;
    end
    if (mrstSlot >= 0) begin
      mCapturing = 0; mArmed = 0; mPaused = 0;
      mCount = 0; mOvf = 0; mFerr = 0;
      expRst = 1;
    end

    wrPulses  = 0;
    wrSlot    = -1;
    wrData    = '0;
    rstCycles = 0;
    for (int k = 0; k < 64; k++) begin
      @(negedge SND_BCLK);
      if (FIFOWR === 1'b1) begin
        wrPulses++;
        wrSlot = k;
        wrData = FIFODIN;
      end
      if (FIFORST === 1'b1) rstCycles++;
      SND_LRCLK = (k < riseSlot) ? 1'b0 : 1'b1;
      if (k >= 1 && k <= SB)                SND_DIN = l[SB - k];
      else if (k >= 33 && k <= 32 + SB)     SND_DIN = r[32 + SB - k];
      else                                  SND_DIN = 1'($urandom_range(0, 1));
      COMMAND  = (k == cmdSlot) ? cmdVal : 2'b00;
      MRST     = (k == mrstSlot);
      FIFOFULL = full;
    end
    FIFOFULL = 1'b0;

    checkOutput({name, ".writes"}, 32'(wrPulses), 32'(expWrite));
    if (expWrite) begin
      checkOutput({name, ".wrslot"}, 32'(wrSlot), 32'(WRITE_SLOT));
      checkOutput({name, ".data"}, wrData, {l, r});
    end
    checkOutput({name, ".fiforst"}, 32'(rstCycles), 32'(expRst));
    checkOutput({name, ".wrcnt"}, 32'(WRCNT), 32'(mCount));
    checkOutput({name, ".overflow"}, 32'(OVERFLOW), 32'(mOvf));
    checkOutput({name, ".frameerr"}, 32'(FRAMEERR), 32'(mFerr));
    checkOutput({name, ".busy"}, 32'(BUSY), 32'(mCapturing || mArmed));
    if (mrstSlot >= 0) checkOutput({name, ".fifodin"}, FIFODIN, 32'h0);
  endtask

  // Directed sequence with randomised sample data and filler bits
  initial begin
    logic [15:0] rl;
    logic [15:0] rr;

    MRST      = 1'b1;
    SND_LRCLK = 1'b1;
    SND_DIN   = 1'b0;
    COMMAND   = 2'b00;
    DATASIZE  = '0;
    FIFOFULL  = 1'b0;
    repeat (3) @(negedge SND_BCLK);
    checkOutput("reset.fiforst", 32'(FIFORST), 32'h1);
    checkOutput("reset.busy", 32'(BUSY), 32'h0);
    checkOutput("reset.wrcnt", 32'(WRCNT), 32'h0);
    checkOutput("reset.fifowr", 32'(FIFOWR), 32'h0);
    checkOutput("reset.fifodin", FIFODIN, 32'h0);
    checkOutput("reset.overflow", 32'(OVERFLOW), 32'h0);
    checkOutput("reset.frameerr", 32'(FRAMEERR), 32'h0);
    MRST = 1'b0;
    @(negedge SND_BCLK);
    @(negedge SND_BCLK);
    checkOutput("release.fiforst", 32'(FIFORST), 32'h0);

    // Word-count limit of 3 with five frames offered
    $display("[TB] limited capture, DATASIZE=3");
    DATASIZE = WW'(3);
    mLimit   = 3;
    issueStart();
    applyStimulus("lim1", 16'hA5C3, 16'h1234, 32, 0, -1, 2'b00, -1);
    for (int i = 2; i <= 5; i++) begin
      rl = 16'($urandom);
      rr = 16'($urandom);
      applyStimulus("limN", rl, rr, 32, 0, -1, 2'b00, -1);
    end

    // Unbounded capture with overflow, framing error, pause/resume, stop
    $display("[TB] unbounded capture");
    DATASIZE = '0;
    mLimit   = 0;
    issueStart();
    for (int i = 0; i < 3; i++)
      applyStimulus("fixed", 16'hA5C3, 16'h1234, 32, 0, -1, 2'b00, -1);
    applyStimulus("full", 16'h0F0F, 16'hF0F0, 32, 1, -1, 2'b00, -1);
    for (int i = 0; i < 3; i++) begin
      rl = 16'($urandom);
      rr = 16'($urandom);
      applyStimulus("rand", rl, rr, 32, 0, -1, 2'b00, -1);
    end
    applyStimulus("badrise", 16'h5555, 16'hAAAA, 30, 0, -1, 2'b00, -1);
    applyStimulus("resync", 16'h8001, 16'h7FFE, 32, 0, -1, 2'b00, -1);
    applyStimulus("pause", 16'h1111, 16'h2222, 32, 0, 20, 2'b10, -1);
    applyStimulus("paused", 16'h3333, 16'h4444, 32, 0, -1, 2'b00, -1);
    applyStimulus("resume", 16'h5555, 16'h6666, 32, 0, 20, 2'b01, -1);
    rl = 16'($urandom);
    rr = 16'($urandom);
    applyStimulus("resumed", rl, rr, 32, 0, -1, 2'b00, -1);
    applyStimulus("stop", 16'h7777, 16'h8888, 32, 0, 20, 2'b11, -1);

    // FIFO full on the middle frame of three, then master reset mid-frame
    $display("[TB] overflow and master reset");
    issueStart();
    applyStimulus("ovf1", 16'hCAFE, 16'hBEEF, 32, 0, -1, 2'b00, -1);
    applyStimulus("ovf2", 16'hDEAD, 16'hFACE, 32, 1, -1, 2'b00, -1);
    applyStimulus("ovf3", 16'h0001, 16'h8000, 32, 0, -1, 2'b00, -1);
    applyStimulus("mrst", 16'h1357, 16'h2468, 32, 0, -1, 2'b00, 40);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
